// File: rtl/pe_array.sv
// 2x16 signed MAC grid: accumulates input[c]*weight[r] over N steps, then rounds half-up and
// publishes all results with a one-cycle rounder_valid pulse. Define PE_ARRAY_SAT_EN to saturate results.
module pe_array #(
    parameter int ROWS      = 2,
    parameter int COLS      = 16,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [COLS*DATA_W-1:0]        data_input_matrix,
    input  logic [ROWS*DATA_W-1:0]        data_weight_matrix,
    input  logic [3:0]                    add_number,
    input  logic                          rounder_en,
    input  logic                          keep,
    output logic [ROWS*COLS*DATA_W-1:0]   pe_array_out,
    output logic                          rounder_valid,
    output logic [3:0]                    round_number
);

    localparam logic signed [ACC_W-1:0] HALF =
        (FRAC_BITS == 0) ? '0 : ACC_W'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0);
`ifdef PE_ARRAY_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    function automatic logic [DATA_W-1:0] round_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = (v + HALF) >>> FRAC_BITS;
`ifdef PE_ARRAY_SAT_EN
        if (t > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (t < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return t[DATA_W-1:0];
`else
        return t[DATA_W-1:0];
`endif
    endfunction

    logic signed [ACC_W-1:0]       r_acc [ROWS][COLS];
    logic signed [ACC_W-1:0]       w_sum [ROWS][COLS];
    logic [3:0]                    r_cnt;
    logic [3:0]                    w_n_m1;
    logic                          w_step;
    logic                          w_last;
    logic [ROWS*COLS*DATA_W-1:0]   r_out;
    logic                          r_valid;

    // add_number=0 wraps to 15, i.e. a 16-step round.
    assign w_n_m1 = add_number - 4'd1;
    assign w_step = rounder_en & ~keep;
    // >= so that shrinking N mid-round closes the round on the very next step.
    assign w_last = w_step && (r_cnt >= w_n_m1);

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic signed [DATA_W-1:0]   w_a;
                logic signed [DATA_W-1:0]   w_b;
                logic signed [2*DATA_W-1:0] w_p;
                w_a = data_input_matrix[c*DATA_W +: DATA_W];
                w_b = data_weight_matrix[r*DATA_W +: DATA_W];
                w_p = w_a * w_b;
                w_sum[r][c] = (r_cnt == 4'd0) ? ACC_W'(w_p) : r_acc[r][c] + ACC_W'(w_p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_acc[r][c] <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_step) begin
                r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        r_acc[r][c] <= w_sum[r][c];
                        if (w_last)
                            r_out[(r*COLS+c)*DATA_W +: DATA_W] <= round_clamp(w_sum[r][c]);
                    end
                end
            end
        end
    end

    assign pe_array_out  = r_out;
    assign rounder_valid = r_valid;
    assign round_number  = r_cnt;

endmodule

// File: tb/tb_pe_array.sv
// Directed bench for pe_array: table of single-round vectors plus hand sequences for stall,
// mid-round reset, back-to-back rounds and a mid-round change of add_number.
module tb_pe_array;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [255:0]   data_input_matrix;
    logic [31:0]    data_weight_matrix;
    logic [3:0]     add_number;
    logic           rounder_en;
    logic           keep;
    logic [511:0]   pe_array_out;
    logic           rounder_valid;
    logic [3:0]     round_number;

    int checks = 0;
    int errors = 0;

    pe_array dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_input_matrix  (data_input_matrix),
        .data_weight_matrix (data_weight_matrix),
        .add_number         (add_number),
        .rounder_en         (rounder_en),
        .keep               (keep),
        .pe_array_out       (pe_array_out),
        .rounder_valid      (rounder_valid),
        .round_number       (round_number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in_all;
        logic [15:0] in5;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [3:0]  addn;
        int          steps;
        logic [15:0] e0;
        logic [15:0] e05;
        logic [15:0] e1;
        logic [15:0] e15;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] in_all, input logic [15:0] in5,
                            input logic [15:0] w0, input logic [15:0] w1);
        for (int c = 0; c < 16; c++)
            data_input_matrix[c*16 +: 16] = (c == 5) ? in5 : in_all;
        data_weight_matrix = {w1, w0};
    endtask

    task automatic check_out(input string tag, input logic [15:0] e0, input logic [15:0] e05,
                             input logic [15:0] e1, input logic [15:0] e15);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                logic [15:0] exp;
                if (r == 0) exp = (c == 5) ? e05 : e0;
                else        exp = (c == 5) ? e15 : e1;
                chk($sformatf("%s_out_r%0d_c%0d", tag, r, c),
                    32'(pe_array_out[r*256 + c*16 +: 16]), 32'(exp));
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rounder_en = 1'b0;
        keep       = 1'b0;
        rst_n      = 1'b1;
        tick();
        rst_n      = 1'b0;
        chk({tag, "_rst_cnt"},   32'(round_number), 32'd0);
        chk({tag, "_rst_valid"}, 32'(rounder_valid), 32'd0);
        chk({tag, "_rst_out"},   32'(pe_array_out == '0), 32'd1);
    endtask

    // One step with valid expected or not after the edge, and the resulting counter value.
    task automatic step(input string tag, input logic exp_vld, input logic [3:0] exp_cnt);
        rounder_en = 1'b1;
        keep       = 1'b0;
        tick();
        rounder_en = 1'b0;
        chk({tag, "_valid"}, 32'(rounder_valid), 32'(exp_vld));
        chk({tag, "_cnt"},   32'(round_number), 32'(exp_cnt));
    endtask

    initial begin
        logic [15:0] sat_pos;
        logic [15:0] sat_neg;
`ifdef PE_ARRAY_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'hFE00;
        sat_neg = 16'h0100;
`endif
        // in_all, in5, w0, w1, addn, steps, e0, e05, e1, e15
        vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd4, 4,  16'h0400, 16'h0400, 16'h0400, 16'h0400};
        vecs[1] = '{16'hFF00, 16'h0001, 16'h0180, 16'h0080, 4'd1, 1,  16'hFE80, 16'h0002, 16'hFF80, 16'h0001};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd0, 16, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'd2, 2,  sat_pos,  sat_pos,  sat_pos,  sat_pos};
        vecs[4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 4'd2, 2,  sat_neg,  sat_neg,  sat_neg,  sat_neg};
        vecs[5] = '{16'h0200, 16'h0200, 16'hFF00, 16'h0040, 4'd3, 3,  16'hFA00, 16'hFA00, 16'h0180, 16'h0180};

        rst_n = 1'b1;
        rounder_en = 1'b0;
        keep = 1'b0;
        add_number = 4'd4;
        set_data(16'h0, 16'h0, 16'h0, 16'h0);
        tick();

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset(tag);
            add_number = vecs[v].addn;
            set_data(vecs[v].in_all, vecs[v].in5, vecs[v].w0, vecs[v].w1);
            for (int s = 0; s < vecs[v].steps; s++) begin
                logic last;
                last = (s == vecs[v].steps - 1);
                step($sformatf("%s_s%0d", tag, s), last, last ? 4'd0 : 4'(s + 1));
            end
            check_out(tag, vecs[v].e0, vecs[v].e05, vecs[v].e1, vecs[v].e15);
            tick();
            chk({tag, "_idle_valid"}, 32'(rounder_valid), 32'd0);
            chk({tag, "_hold_out"}, 32'(pe_array_out[15:0]), 32'(vecs[v].e0));
        end

        // Stall: keep overrides rounder_en for three cycles mid-round.
        do_reset("stall");
        add_number = 4'd4;
        set_data(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        step("stall_s0", 1'b0, 4'd1);
        step("stall_s1", 1'b0, 4'd2);
        for (int k = 0; k < 3; k++) begin
            rounder_en = 1'b1;
            keep = 1'b1;
            tick();
            chk($sformatf("stall_k%0d_cnt", k), 32'(round_number), 32'd2);
            chk($sformatf("stall_k%0d_valid", k), 32'(rounder_valid), 32'd0);
        end
        keep = 1'b0;
        step("stall_s2", 1'b0, 4'd3);
        step("stall_s3", 1'b1, 4'd0);
        check_out("stall", 16'h0400, 16'h0400, 16'h0400, 16'h0400);

        // Reset mid-round: the partial round is discarded.
        do_reset("mrst");
        add_number = 4'd4;
        step("mrst_a0", 1'b0, 4'd1);
        step("mrst_a1", 1'b0, 4'd2);
        do_reset("mrst2");
        for (int s = 0; s < 4; s++)
            step($sformatf("mrst_b%0d", s), s == 3, (s == 3) ? 4'd0 : 4'(s + 1));
        check_out("mrst", 16'h0400, 16'h0400, 16'h0400, 16'h0400);

        // Back-to-back rounds of N=2 with no bubble between them.
        do_reset("b2b");
        add_number = 4'd2;
        step("b2b_s0", 1'b0, 4'd1);
        step("b2b_s1", 1'b1, 4'd0);
        set_data(16'h0200, 16'h0200, 16'h0100, 16'h0100);
        step("b2b_s2", 1'b0, 4'd1);
        chk("b2b_mid_hold", 32'(pe_array_out[15:0]), 32'h0200);
        step("b2b_s3", 1'b1, 4'd0);
        check_out("b2b", 16'h0400, 16'h0400, 16'h0400, 16'h0400);

        // Shrinking N mid-round: counter already past new N-1, so the next step ends it.
        do_reset("chg");
        set_data(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        add_number = 4'd8;
        step("chg_s0", 1'b0, 4'd1);
        step("chg_s1", 1'b0, 4'd2);
        step("chg_s2", 1'b0, 4'd3);
        add_number = 4'd2;
        step("chg_s3", 1'b1, 4'd0);
        check_out("chg", 16'h0400, 16'h0400, 16'h0400, 16'h0400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
